// File: rtl/bp_table_writer_pkg.sv
// Shared constants and state encoding for the bad-pixel table merge.
package bp_table_writer_pkg;
  localparam int CNT_W = 10;
  localparam int KEY_W = 2 * CNT_W;
  localparam int X_LSB = 16;
  localparam int Y_LSB = 0;

  typedef enum logic [2:0] {IDLE, LOAD, CMP, DRAIN, DONE} state_t;
endpackage

// File: rtl/bp_head_reg.sv
// Single-entry holding register with a full flag; the key lives here until consumed.
module bp_head_reg
  import bp_table_writer_pkg::*;
#(
  parameter int W = KEY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         consume,
  output logic         full,
  output logic [W-1:0] dout
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          full <= 1'b0;
    else if (clr)     full <= 1'b0;
    else if (load)    full <= 1'b1;
    else if (consume) full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) dout <= din;
  end
endmodule

// File: rtl/bp_table_writer.sv
// Merges the raster-ordered manual and auto bad-pixel lists into one table sorted by {y,x}.
module bp_table_writer
  import bp_table_writer_pkg::*;
#(
  parameter int CNT_WIDTH  = KEY_W / 2,
  parameter int ALL_BP_NUM = 512,
  parameter int ALL_BP_BIT = 9,
  parameter int MAN_BP_BIT = 7
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [MAN_BP_BIT:0]   manual_bp_num,
  output logic [MAN_BP_BIT-1:0] manual_raddr,
  input  logic [31:0]           manual_rdata,
  input  logic [ALL_BP_BIT:0]   auto_bp_num,
  input  logic                  auto_bp_valid,
  output logic                  auto_bp_ready,
  input  logic [CNT_WIDTH-1:0]  auto_bp_x,
  input  logic [CNT_WIDTH-1:0]  auto_bp_y,
  output logic                  all_bp_wen,
  output logic [ALL_BP_BIT-1:0] all_bp_waddr,
  output logic [31:0]           all_bp_wdata,
  output logic [ALL_BP_BIT:0]   all_bp_num,
  output logic                  bp_table_ready,
  output logic                  busy,
  output logic                  overflow,
  output logic                  order_err
);
  localparam int HW = 2 * CNT_WIDTH;
  localparam logic [ALL_BP_BIT:0] TABLE_DEPTH = (ALL_BP_BIT+1)'(ALL_BP_NUM);
  typedef logic [HW-1:0] key_t;

  state_t              state;
  logic [MAN_BP_BIT:0] man_total, man_idx, man_idx_d;
  logic [ALL_BP_BIT:0] auto_total, auto_cnt, wcount;
  key_t                last_key, m_key, a_key, sel_key;
  logic                have_last, m_full, a_full, m_full_n, a_full_n, m_exh, a_exh, go;
  logic                m_load, a_xfer, m_take, a_take, clr_heads, unused_rdata;

  function automatic logic [31:0] pack_entry(input key_t k);
    logic [31:0] w;
    w = '0;
    w[X_LSB +: CNT_WIDTH] = k[CNT_WIDTH-1:0];
    w[Y_LSB +: CNT_WIDTH] = k[HW-1:CNT_WIDTH];
    return w;
  endfunction

  assign clr_heads    = (state == IDLE) && start;
  assign unused_rdata = ^manual_rdata;
  // The RAM sees the index the fetch counter is about to hold, so rdata always matches man_idx.
  assign manual_raddr = man_idx_d[MAN_BP_BIT-1:0];
  assign auto_bp_ready = !a_full && (auto_cnt < auto_total) && (state != IDLE) && (state != DONE);
  assign a_xfer = auto_bp_valid && auto_bp_ready;

  always_comb begin
    m_load    = (state == LOAD) && !m_full && (man_idx < man_total);
    man_idx_d = man_idx;
    if (clr_heads)   man_idx_d = '0;
    else if (m_load) man_idx_d = man_idx + 1'b1;
    m_full_n = m_full | m_load;
    a_full_n = a_full | a_xfer;
    m_exh    = !m_full_n && (man_idx == man_total);
    a_exh    = !a_full_n && (auto_cnt == auto_total);
    go       = (m_full_n || m_exh) && (a_full_n || a_exh);
    m_take   = 1'b0;
    a_take   = 1'b0;
    if (state == CMP) begin
      m_take = (m_key <= a_key);
      a_take = (a_key <= m_key);
    end else if (state == DRAIN) begin
      m_take = m_full;
      a_take = a_full;
    end
    sel_key = m_take ? m_key : a_key;
  end

  bp_head_reg #(.W(HW)) u_man_head (
    .clk(aclk), .rst(areset), .clr(clr_heads), .load(m_load),
    .din({manual_rdata[Y_LSB +: CNT_WIDTH], manual_rdata[X_LSB +: CNT_WIDTH]}),
    .consume(m_take), .full(m_full), .dout(m_key)
  );

  bp_head_reg #(.W(HW)) u_auto_head (
    .clk(aclk), .rst(areset), .clr(clr_heads), .load(a_xfer),
    .din({auto_bp_y, auto_bp_x}),
    .consume(a_take), .full(a_full), .dout(a_key)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= IDLE;
      man_total      <= '0;
      man_idx        <= '0;
      auto_total     <= '0;
      auto_cnt       <= '0;
      wcount         <= '0;
      last_key       <= '0;
      have_last      <= 1'b0;
      all_bp_wen     <= 1'b0;
      all_bp_waddr   <= '0;
      all_bp_wdata   <= '0;
      all_bp_num     <= '0;
      bp_table_ready <= 1'b0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
      order_err      <= 1'b0;
    end else begin
      all_bp_wen <= 1'b0;
      man_idx    <= man_idx_d;
      if (a_xfer) auto_cnt <= auto_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          man_total      <= manual_bp_num;
          auto_total     <= auto_bp_num;
          auto_cnt       <= '0;
          wcount         <= '0;
          have_last      <= 1'b0;
          overflow       <= 1'b0;
          order_err      <= 1'b0;
          bp_table_ready <= 1'b0;
          busy           <= 1'b1;
          state          <= LOAD;
        end
        LOAD: if (go) begin
          if (m_exh && a_exh) begin
            all_bp_num     <= wcount;
            bp_table_ready <= 1'b1;
            busy           <= 1'b0;
            state          <= DONE;
          end else begin
            state <= (m_full_n && a_full_n) ? CMP : DRAIN;
          end
        end
        CMP, DRAIN: begin
          // Entries are dropped when not above the last key; once full, kept entries are discarded.
          if (have_last && (sel_key <= last_key)) begin
            order_err <= 1'b1;
          end else begin
            last_key  <= sel_key;
            have_last <= 1'b1;
            if (wcount == TABLE_DEPTH) begin
              overflow <= 1'b1;
            end else begin
              all_bp_wen   <= 1'b1;
              all_bp_waddr <= wcount[ALL_BP_BIT-1:0];
              all_bp_wdata <= pack_entry(sel_key);
              wcount       <= wcount + 1'b1;
            end
          end
          state <= LOAD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_table_writer.sv
// Scoreboard bench for bp_table_writer: expected writes queued by stimulus, popped by a write monitor.
module tb_bp_table_writer;
  logic        aclk = 1'b0;
  logic        areset, start;
  logic [7:0]  manual_bp_num;
  logic [6:0]  manual_raddr;
  logic [31:0] manual_rdata;
  logic [9:0]  auto_bp_num;
  logic        auto_bp_valid, auto_bp_ready;
  logic [9:0]  auto_bp_x, auto_bp_y;
  logic        all_bp_wen;
  logic [8:0]  all_bp_waddr;
  logic [31:0] all_bp_wdata;
  logic [9:0]  all_bp_num;
  logic        bp_table_ready, busy, overflow, order_err;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_seen = 0;
  bit gap_mode = 1'b0;
  logic [31:0] man_mem [128];
  logic [19:0] auto_q [$];
  logic [40:0] exp_q [$];
  logic [40:0] mon_e;

  bp_table_writer #(.CNT_WIDTH(10), .ALL_BP_NUM(4), .ALL_BP_BIT(9), .MAN_BP_BIT(7)) dut (
    .aclk(aclk), .areset(areset), .start(start),
    .manual_bp_num(manual_bp_num), .manual_raddr(manual_raddr), .manual_rdata(manual_rdata),
    .auto_bp_num(auto_bp_num), .auto_bp_valid(auto_bp_valid), .auto_bp_ready(auto_bp_ready),
    .auto_bp_x(auto_bp_x), .auto_bp_y(auto_bp_y),
    .all_bp_wen(all_bp_wen), .all_bp_waddr(all_bp_waddr), .all_bp_wdata(all_bp_wdata),
    .all_bp_num(all_bp_num), .bp_table_ready(bp_table_ready), .busy(busy),
    .overflow(overflow), .order_err(order_err)
  );

  always #5 aclk = ~aclk;

  // Synchronous manual RAM: data appears the cycle after the address.
  always @(posedge aclk) manual_rdata <= man_mem[manual_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int a, input logic [31:0] d);
    exp_q.push_back({9'(a), d});
  endtask

  function automatic logic [19:0] ent(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction

  // Auto source: optional 1-in-3 valid pattern.
  initial begin
    int phase;
    phase = 0;
    auto_bp_valid = 1'b0;
    auto_bp_x = '0;
    auto_bp_y = '0;
    forever begin
      @(negedge aclk);
      phase = (phase == 2) ? 0 : phase + 1;
      if (auto_q.size() > 0 && (!gap_mode || phase == 0)) begin
        auto_bp_valid = 1'b1;
        auto_bp_x = auto_q[0][19:10];
        auto_bp_y = auto_q[0][9:0];
      end else begin
        auto_bp_valid = 1'b0;
      end
      #1;
      if (auto_bp_valid && auto_bp_ready) void'(auto_q.pop_front());
    end
  end

  // Write monitor
  initial begin
    forever begin
      @(negedge aclk);
      if (all_bp_wen === 1'b1) begin
        wr_seen++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h want no write", all_bp_waddr, all_bp_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if ({all_bp_waddr, all_bp_wdata} !== mon_e) begin
            n_fail++;
            $display("FAIL table_write: got addr %0d data 0x%0h want addr %0d data 0x%0h",
                     all_bp_waddr, all_bp_wdata, mon_e[40:32], mon_e[31:0]);
          end
        end
      end
    end
  end

  task automatic run(input string tag, input int mcnt, input int acnt, input bit gap, input bit poke,
                     input int exp_num, input bit exp_ovf, input bit exp_oerr, input int max_cyc);
    int cyc;
    bit done;
    gap_mode = gap;
    @(negedge aclk);
    manual_bp_num = 8'(mcnt);
    auto_bp_num   = 10'(acnt);
    start = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < max_cyc) begin
      @(negedge aclk);
      #2;
      start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_ready_low"}, 32'(bp_table_ready), 32'd0);
      end
      if (poke && cyc == 3) start = 1'b1;
      if (bp_table_ready) done = 1'b1;
    end
    chk({tag, "_done_in_time"}, 32'(done), 32'd1);
    chk({tag, "_num"}, 32'(all_bp_num), 32'(exp_num));
    chk({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_order_err"}, 32'(order_err), 32'(exp_oerr));
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_auto_left"}, 32'(auto_q.size()), 32'd0);
  endtask

  task automatic load_basic();
    man_mem[0] = 32'h0002_0001;
    man_mem[1] = 32'h0005_0003;
    auto_q.delete();
    auto_q.push_back(ent(3, 1));
    auto_q.push_back(ent(5, 3));
    auto_q.push_back(ent(0, 4));
  endtask

  task automatic expect_basic();
    exp_wr(0, 32'h0002_0001);
    exp_wr(1, 32'h0003_0001);
    exp_wr(2, 32'h0005_0003);
    exp_wr(3, 32'h0000_0004);
  endtask

  initial begin
    int cyc;
    int base;
    areset = 1'b1;
    start = 1'b0;
    manual_bp_num = '0;
    auto_bp_num = '0;
    for (int i = 0; i < 128; i++) man_mem[i] = '0;
    repeat (3) @(negedge aclk);
    chk("rst_wen", 32'(all_bp_wen), 32'd0);
    chk("rst_ready", 32'(bp_table_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_num", 32'(all_bp_num), 32'd0);
    chk("rst_raddr", 32'(manual_raddr), 32'd0);
    areset = 1'b0;

    // Basic interleaved merge with one duplicate key
    load_basic();
    expect_basic();
    run("basic", 2, 3, 1'b0, 1'b0, 4, 1'b0, 1'b0, 12);

    // Both lists empty
    run("zero", 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2);

    // Table depth 4 overflowed by six disjoint entries
    man_mem[0] = 32'h0001_0000;
    man_mem[1] = 32'h0003_0000;
    man_mem[2] = 32'h0005_0000;
    auto_q.delete();
    auto_q.push_back(ent(2, 0));
    auto_q.push_back(ent(4, 0));
    auto_q.push_back(ent(6, 0));
    exp_wr(0, 32'h0001_0000);
    exp_wr(1, 32'h0002_0000);
    exp_wr(2, 32'h0003_0000);
    exp_wr(3, 32'h0004_0000);
    run("ovf", 3, 3, 1'b0, 1'b0, 4, 1'b1, 1'b0, 40);

    // Out-of-order auto list
    auto_q.delete();
    auto_q.push_back(ent(7, 2));
    auto_q.push_back(ent(1, 2));
    exp_wr(0, 32'h0007_0002);
    run("order", 0, 2, 1'b0, 1'b0, 1, 1'b0, 1'b1, 20);

    // Sparse valid plus a start pulse while busy
    load_basic();
    expect_basic();
    run("gap", 2, 3, 1'b1, 1'b1, 4, 1'b0, 1'b0, 80);

    // Reset after the second write, then a clean rebuild
    load_basic();
    exp_wr(0, 32'h0002_0001);
    exp_wr(1, 32'h0003_0001);
    gap_mode = 1'b0;
    base = wr_seen;
    @(negedge aclk);
    manual_bp_num = 8'd2;
    auto_bp_num = 10'd3;
    start = 1'b1;
    cyc = 0;
    while (wr_seen < base + 2 && cyc < 50) begin
      @(negedge aclk);
      #2;
      start = 1'b0;
      cyc++;
    end
    chk("mid_writes_seen", 32'(wr_seen - base), 32'd2);
    areset = 1'b1;
    #1;
    chk("mid_rst_wen", 32'(all_bp_wen), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_auto_ready", 32'(auto_bp_ready), 32'd0);
    chk("mid_rst_waddr", 32'(all_bp_waddr), 32'd0);
    chk("mid_rst_wdata", all_bp_wdata, 32'd0);
    chk("mid_rst_raddr", 32'(manual_raddr), 32'd0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    chk("mid_rst_num", 32'(all_bp_num), 32'd0);
    chk("mid_rst_ready", 32'(bp_table_ready), 32'd0);
    load_basic();
    expect_basic();
    run("rebuild", 2, 3, 1'b0, 1'b0, 4, 1'b0, 1'b0, 12);

    repeat (3) @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_table_writer.md
BP_TABLE_WRITER -- requirements
Module: bp_table_writer

Interface
REQ-001 Parameter CNT_WIDTH, 10, coordinate width.
REQ-002 Parameter ALL_BP_NUM, 512, merged table depth; ALL_BP_BIT, 9, merged table address width.
REQ-003 Parameter MAN_BP_BIT, 7, manual list address width.
REQ-004 aclk  in  1  sole clock; areset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  pulse; begins a merge.
REQ-006 manual_bp_num  in  MAN_BP_BIT+1  manual entry count; manual_raddr  out  MAN_BP_BIT  manual RAM read address; manual_rdata  in  32  {x[31:16], y[15:0]}, valid one cycle after manual_raddr.
REQ-007 auto_bp_num  in  ALL_BP_BIT+1  auto entry count; auto_bp_valid  in  1; auto_bp_ready  out  1; auto_bp_x, auto_bp_y  in  CNT_WIDTH each.
REQ-008 all_bp_wen  out  1; all_bp_waddr  out  ALL_BP_BIT; all_bp_wdata  out  32; all_bp_num  out  ALL_BP_BIT+1; bp_table_ready  out  1.
REQ-009 busy, overflow, order_err  out  1 each  status.

Function
REQ-010 Both inputs SHALL be raster-ordered lists; the block SHALL write their union to the table in strictly ascending key {y,x}, because the corrector walks the table sequentially.
REQ-011 start while IDLE SHALL latch both counts, clear write count, overflow and order_err, drop bp_table_ready and assert busy on the next cycle. start while busy SHALL be ignored.
REQ-012 FSM states: IDLE, LOAD (issue manual read), CMP, DRAIN, DONE. IDLE->LOAD on start; LOAD->CMP once every non-exhausted head register is full; CMP->LOAD after each write or drop; exhaustion of both lists->DONE; DONE->IDLE after one cycle.
REQ-013 Manual head: manual_raddr SHALL be driven one cycle, manual_rdata captured the next cycle; manual_raddr SHALL increment per consumed entry.
REQ-014 Auto head: auto_bp_ready SHALL be 1 only while the auto head register is empty, consumed count < auto_bp_num and state is not IDLE/DONE; a transfer is valid&&ready.
REQ-015 CMP: smaller key written and its head consumed; equal keys written once, both heads consumed; one list exhausted -> other list written in order.
REQ-016 Write: one all_bp_wen pulse per entry, waddr = current write count, wdata = {zero-extended x to 16 bits, zero-extended y to 16 bits}; count increments on the same edge.
REQ-017 Entry with key <= last written key (not first write) SHALL be dropped, order_err set sticky until next start.
REQ-018 When write count = ALL_BP_NUM, further entries SHALL be consumed without writing and overflow set sticky; auto_bp_ready SHALL continue until auto_bp_num entries consumed.
REQ-019 Zero counts: both zero -> DONE within 2 cycles, all_bp_num = 0, bp_table_ready = 1.
REQ-020 In DONE, all_bp_num SHALL load the final write count and bp_table_ready SHALL assert and hold until next start; busy deasserts together.
REQ-021 Throughput: at most one write per 2 cycles; merge of N unique entries SHALL finish within 2N+4 cycles given continuous auto_bp_valid.

Reset
REQ-022 areset SHALL force IDLE; all_bp_wen, auto_bp_ready, busy, overflow, order_err, bp_table_ready = 0; all_bp_num, all_bp_waddr, all_bp_wdata, manual_raddr = 0; head registers empty.
REQ-023 areset mid-merge SHALL abandon the merge; no write pulse after reset assertion.

Structure
REQ-024 Shared package: key-compare width constant (2*CNT_WIDTH), wdata field offsets (X_LSB=16, Y_LSB=0), FSM state enum.
REQ-025 One sub-module natural: bp_head_reg (holding register with full/empty flag, used for both manual and auto heads).

Verification
REQ-026 manual {(2,1),(5,3)}, auto {(3,1),(5,3),(0,4)} -> writes addr0..3 = (2,1),(3,1),(5,3),(0,4); all_bp_num=4; bp_table_ready=1.
REQ-027 manual count 0, auto count 0, start -> bp_table_ready=1 within 2 cycles, all_bp_num=0, no all_bp_wen.
REQ-028 ALL_BP_NUM=4, manual 3 + auto 3 disjoint -> 4 writes, overflow=1, all 3 auto entries accepted, all_bp_num=4.
REQ-029 auto {(7,2),(1,2)} -> (1,2) dropped, order_err=1, all_bp_num=1.
REQ-030 auto_bp_valid toggled 1-in-3 cycles -> same table contents as continuous valid; start during busy ignored.
REQ-031 areset asserted after 2nd write -> outputs at reset values next edge; fresh start rebuilds complete table from addr 0.
